ysyx_22041752_mem_arbiter: RTL

- Two-to-one arbiter sharing the single SRAM-style memory port between the IFU instruction-fetch channel and the LSU data channel.
- Accepts en/ready requests from both masters, grants exactly one, and issues a registered request to memory.
- Routes the single response pulse back to the granted master.
- Allows one outstanding transaction at a time; sits between the core pipeline and the memory/AXI bridge.

---
 rtl/ysyx_22041752_mem_arbiter_pkg.sv | 18 +
 rtl/ysyx_22041752_mem_arbiter_pick.sv | 32 +++
 rtl/ysyx_22041752_mem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/ysyx_22041752_mem_arbiter_pkg.sv
// Shared encodings and default widths for the IFU/LSU memory-port arbiter.
package ysyx_22041752_mem_arbiter_pkg;

  localparam int ARB_ADDR_WD = 32;
  localparam int ARB_DATA_WD = 64;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_REQ  = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ysyx_22041752_mem_arbiter_pick.sv
// Combinational grant selector: fixed data-over-inst priority, or round-robin
// when YSYX_22041752_ARB_RR_EN is defined.
module ysyx_22041752_arb_pick
  import ysyx_22041752_mem_arbiter_pkg::*;
(
  input  logic       inst_en_i,
  input  logic       data_en_i,
`ifdef YSYX_22041752_ARB_RR_EN
  input  arb_owner_e last_grant_i,
`endif
  output logic       grant_vld_o,
  output arb_owner_e grant_owner_o
);

  always_comb begin
    grant_vld_o   = inst_en_i | data_en_i;
    grant_owner_o = OWN_INST;
`ifdef YSYX_22041752_ARB_RR_EN
    // On a tie the master that did not win last time goes first.
    if (inst_en_i && data_en_i) begin
      grant_owner_o = (last_grant_i == OWN_INST) ? OWN_DATA : OWN_INST;
    end else if (data_en_i) begin
      grant_owner_o = OWN_DATA;
    end
`else
    if (data_en_i) begin
      grant_owner_o = OWN_DATA;
    end
`endif
  end

endmodule

// File: rtl/ysyx_22041752_mem_arbiter.sv
// Two-to-one IFU/LSU arbiter for the single SRAM-style memory port, one
// outstanding transaction. Optional round-robin: YSYX_22041752_ARB_RR_EN.
module ysyx_22041752_mem_arbiter
  import ysyx_22041752_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WD = ARB_ADDR_WD,
  parameter int DATA_WD = ARB_DATA_WD,
  parameter int STRB_WD = DATA_WD / 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               inst_en,
  input  logic [ADDR_WD-1:0] inst_addr,
  output logic               inst_ready,
  output logic               inst_valid,
  output logic [DATA_WD-1:0] inst_rdata,
  input  logic               data_en,
  input  logic [STRB_WD-1:0] data_wen,
  input  logic [ADDR_WD-1:0] data_addr,
  input  logic [DATA_WD-1:0] data_wdata,
  output logic               data_ready,
  output logic               data_valid,
  output logic [DATA_WD-1:0] data_rdata,
  output logic               mem_en,
  output logic [STRB_WD-1:0] mem_wen,
  output logic [ADDR_WD-1:0] mem_addr,
  output logic [DATA_WD-1:0] mem_wdata,
  input  logic               mem_ready,
  input  logic               mem_valid,
  input  logic [DATA_WD-1:0] mem_rdata
);

  arb_state_e         state_q, state_d;
  arb_owner_e         owner_q, owner_d;
  logic               mem_en_q, mem_en_d;
  logic [STRB_WD-1:0] mem_wen_q, mem_wen_d;
  logic [ADDR_WD-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WD-1:0] mem_wdata_q, mem_wdata_d;

  logic               grant_vld;
  arb_owner_e         grant_owner;
  logic               ack, rsp;

`ifdef YSYX_22041752_ARB_RR_EN
  arb_owner_e last_grant_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_q <= OWN_INST;
    end else if (state_q == ARB_IDLE && grant_vld) begin
      last_grant_q <= grant_owner;
    end
  end
`endif

  ysyx_22041752_arb_pick u_pick (
    .inst_en_i     (inst_en),
    .data_en_i     (data_en),
`ifdef YSYX_22041752_ARB_RR_EN
    .last_grant_i  (last_grant_q),
`endif
    .grant_vld_o   (grant_vld),
    .grant_owner_o (grant_owner)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_en_d    = mem_en_q;
    mem_wen_d   = mem_wen_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ack         = 1'b0;
    rsp         = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant_vld) begin
          owner_d  = grant_owner;
          mem_en_d = 1'b1;
          state_d  = ARB_REQ;
          if (grant_owner == OWN_DATA) begin
            mem_wen_d   = data_wen;
            mem_addr_d  = data_addr;
            mem_wdata_d = data_wdata;
          end else begin
            mem_wen_d   = '0;
            mem_addr_d  = inst_addr;
            mem_wdata_d = '0;
          end
        end
      end
      ARB_REQ: begin
        if (mem_ready) begin
          ack      = 1'b1;
          mem_en_d = 1'b0;
          // Zero-latency memory: response completes together with the accept.
          if (mem_valid) begin
            rsp     = 1'b1;
            state_d = ARB_IDLE;
          end else begin
            state_d = ARB_RESP;
          end
        end
      end
      ARB_RESP: begin
        if (mem_valid) begin
          rsp     = 1'b1;
          state_d = ARB_IDLE;
        end
      end
      default: begin
        state_d  = ARB_IDLE;
        mem_en_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ARB_IDLE;
      owner_q     <= OWN_INST;
      mem_en_q    <= 1'b0;
      mem_wen_q   <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_en_q    <= mem_en_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign inst_ready = ack && (owner_q == OWN_INST);
  assign data_ready = ack && (owner_q == OWN_DATA);
  assign inst_valid = rsp && (owner_q == OWN_INST);
  assign data_valid = rsp && (owner_q == OWN_DATA);
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;
  assign mem_en     = mem_en_q;
  assign mem_wen    = mem_wen_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule
